// File: rtl/axi_s_frame_peak_detect.sv
`default_nettype none
// axi_s_frame_peak_detect: reports peak magnitude, its beat index, frame length, tid and status per frame.
// Revision 1.0
module axi_s_frame_peak_detect #(
  parameter int S_TDATA_WIDTH = 32,
  parameter int TID_WIDTH     = 2,
  parameter int INDEX_WIDTH   = 16
) (
  input  logic                     ss_clk_i,
  input  logic                     ss_aresetn_i,
  input  logic                     ss_tvalid_i,
  input  logic                     ss_tlast_i,
  input  logic [TID_WIDTH-1:0]     ss_tid_i,
  input  logic [S_TDATA_WIDTH-1:0] ss_tdata_i,
  output logic                     ss_tready_o,
  output logic                     sm_clk_o,
  output logic                     sm_aresetn_o,
  output logic                     sm_tvalid_o,
  output logic                     sm_tlast_o,
  output logic [TID_WIDTH-1:0]     sm_tid_o,
  output logic [S_TDATA_WIDTH-1:0] sm_tdata_peak_o,
  output logic [INDEX_WIDTH-1:0]   sm_tindex_o,
  output logic [INDEX_WIDTH-1:0]   sm_tlen_o,
  output logic [1:0]               sm_tuser_o,
  input  logic                     sm_tready_i
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [INDEX_WIDTH-1:0] CNT_ONE = INDEX_WIDTH'(1);

  state_t state;
  state_t state_next;

  logic                     accept;
  logic                     cnt_sat;
  logic                     beat_wins;
  logic                     tid_differs;

  logic [S_TDATA_WIDTH-1:0] acc_peak;
  logic [INDEX_WIDTH-1:0]   acc_index;
  logic [INDEX_WIDTH-1:0]   acc_count;
  logic [TID_WIDTH-1:0]     acc_tid;
  logic [1:0]               acc_flags;

  logic [S_TDATA_WIDTH-1:0] peak_next;
  logic [INDEX_WIDTH-1:0]   index_next;
  logic [INDEX_WIDTH-1:0]   count_next;
  logic [TID_WIDTH-1:0]     tid_next;
  logic [1:0]               flags_next;

  assign sm_clk_o     = ss_clk_i;
  assign sm_aresetn_o = ss_aresetn_i;
  assign sm_tlast_o   = sm_tvalid_o;

  // Input only stalls when a pending result is not being drained this cycle.
  assign ss_tready_o = !(sm_tvalid_o && !sm_tready_i);
  assign accept      = ss_tvalid_i && ss_tready_o;

  assign cnt_sat     = (acc_count == CNT_MAX);
  assign beat_wins   = (ss_tdata_i > acc_peak);
  assign tid_differs = (ss_tid_i != acc_tid);

  always_ff @(posedge ss_clk_i or negedge ss_aresetn_i) begin
    if (!ss_aresetn_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    peak_next  = acc_peak;
    index_next = acc_index;
    count_next = acc_count;
    tid_next   = acc_tid;
    flags_next = acc_flags;
    if (accept) begin
      if (state == IDLE) begin
        peak_next  = ss_tdata_i;
        index_next = '0;
        count_next = CNT_ONE;
        tid_next   = ss_tid_i;
        flags_next = 2'b00;
      end else begin
        // The pre-increment count is this beat's index; it pins at CNT_MAX once saturated.
        if (beat_wins) begin
          peak_next  = ss_tdata_i;
          index_next = acc_count;
        end
        count_next = cnt_sat ? acc_count : acc_count + CNT_ONE;
        flags_next = acc_flags | {tid_differs, cnt_sat};
      end
      state_next = ss_tlast_i ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge ss_clk_i or negedge ss_aresetn_i) begin
    if (!ss_aresetn_i) begin
      acc_peak  <= '0;
      acc_index <= '0;
      acc_count <= '0;
      acc_tid   <= '0;
      acc_flags <= 2'b00;
    end else if (accept) begin
      acc_peak  <= peak_next;
      acc_index <= index_next;
      acc_count <= count_next;
      acc_tid   <= tid_next;
      acc_flags <= flags_next;
    end
  end

  // A new result may load in the same cycle the previous one is taken, so no bubble.
  always_ff @(posedge ss_clk_i or negedge ss_aresetn_i) begin
    if (!ss_aresetn_i) begin
      sm_tvalid_o     <= 1'b0;
      sm_tid_o        <= '0;
      sm_tdata_peak_o <= '0;
      sm_tindex_o     <= '0;
      sm_tlen_o       <= '0;
      sm_tuser_o      <= 2'b00;
    end else if (accept && ss_tlast_i) begin
      sm_tvalid_o     <= 1'b1;
      sm_tid_o        <= tid_next;
      sm_tdata_peak_o <= peak_next;
      sm_tindex_o     <= index_next;
      sm_tlen_o       <= count_next;
      sm_tuser_o      <= flags_next;
    end else if (sm_tready_i) begin
      sm_tvalid_o     <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_s_frame_peak_detect.sv
`default_nettype none
// tb_axi_s_frame_peak_detect: directed and randomized frames checked against a frame-level reference model.
// Revision 1.0
module tb_axi_s_frame_peak_detect;

  localparam int DW   = 32;
  localparam int TW   = 2;
  localparam int IW   = 4;
  localparam int IMAX = (1 << IW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ss_tvalid;
  logic          ss_tlast;
  logic [TW-1:0] ss_tid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tready;
  logic          sm_clk;
  logic          sm_aresetn;
  logic          sm_tvalid;
  logic          sm_tlast;
  logic [TW-1:0] sm_tid;
  logic [DW-1:0] sm_peak;
  logic [IW-1:0] sm_index;
  logic [IW-1:0] sm_len;
  logic [1:0]    sm_user;
  logic          sm_tready;

  always #5 clk = ~clk;

  axi_s_frame_peak_detect #(
    .S_TDATA_WIDTH(DW),
    .TID_WIDTH    (TW),
    .INDEX_WIDTH  (IW)
  ) dut (
    .ss_clk_i       (clk),
    .ss_aresetn_i   (rst_n),
    .ss_tvalid_i    (ss_tvalid),
    .ss_tlast_i     (ss_tlast),
    .ss_tid_i       (ss_tid),
    .ss_tdata_i     (ss_tdata),
    .ss_tready_o    (ss_tready),
    .sm_clk_o       (sm_clk),
    .sm_aresetn_o   (sm_aresetn),
    .sm_tvalid_o    (sm_tvalid),
    .sm_tlast_o     (sm_tlast),
    .sm_tid_o       (sm_tid),
    .sm_tdata_peak_o(sm_peak),
    .sm_tindex_o    (sm_index),
    .sm_tlen_o      (sm_len),
    .sm_tuser_o     (sm_user),
    .sm_tready_i    (sm_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: open-frame beats and the expected pending result.
  logic [DW-1:0] fr_data[$];
  logic [TW-1:0] fr_tid[$];
  bit            exp_valid;
  logic [DW-1:0] e_peak;
  logic [IW-1:0] e_index;
  logic [IW-1:0] e_len;
  logic [TW-1:0] e_tid;
  logic [1:0]    e_user;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic close_frame();
    int n;
    int best;
    bit tid_chg;
    n = fr_data.size();
    best = 0;
    tid_chg = 1'b0;
    for (int i = 1; i < n; i++) begin
      if (fr_data[i] > fr_data[best]) best = i;
      if (fr_tid[i] != fr_tid[0]) tid_chg = 1'b1;
    end
    e_peak    = fr_data[best];
    e_index   = IW'((best > IMAX) ? IMAX : best);
    e_len     = IW'((n > IMAX) ? IMAX : n);
    e_tid     = fr_tid[0];
    e_user    = {tid_chg, (n > IMAX)};
    exp_valid = 1'b1;
    fr_data.delete();
    fr_tid.delete();
  endtask

  task automatic cyc(input bit v, input bit l, input logic [DW-1:0] d, input logic [TW-1:0] t,
                     input bit r, output bit acc);
    bit exp_rdy;
    @(negedge clk);
    ss_tvalid = v;
    ss_tlast  = l;
    ss_tdata  = d;
    ss_tid    = t;
    sm_tready = r;
    #1;
    exp_rdy = !(exp_valid && !r);
    check("tready", 64'(ss_tready), 64'(exp_rdy));
    check("tvalid", 64'(sm_tvalid), 64'(exp_valid));
    check("tlast", 64'(sm_tlast), 64'(exp_valid));
    if (exp_valid) begin
      check("peak", 64'(sm_peak), 64'(e_peak));
      check("index", 64'(sm_index), 64'(e_index));
      check("len", 64'(sm_len), 64'(e_len));
      check("tid", 64'(sm_tid), 64'(e_tid));
      check("tuser", 64'(sm_user), 64'(e_user));
    end
    acc = v && exp_rdy;
    if (exp_valid && r) exp_valid = 1'b0;
    if (acc) begin
      fr_data.push_back(d);
      fr_tid.push_back(t);
      if (l) close_frame();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    ss_tvalid = 1'b0;
    #1;
    check("rst_tvalid", 64'(sm_tvalid), 64'd0);
    check("rst_tlast", 64'(sm_tlast), 64'd0);
    check("rst_fields", {sm_tid, sm_peak, sm_index, sm_len, sm_user}, 64'd0);
    check("rst_aresetn_o", 64'(sm_aresetn), 64'd0);
    fr_data.delete();
    fr_tid.delete();
    exp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("aresetn_o", 64'(sm_aresetn), 64'd1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input bit l, input int rdy_pct);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      cyc(($urandom_range(0, 3) != 0), l, d, t, ($urandom_range(0, 99) < rdy_pct), acc);
      guard++;
      if (guard > 500) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  logic [DW-1:0] vals[5];
  bit            a;

  initial begin
    rst_n     = 1'b0;
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
    ss_tid    = '0;
    ss_tdata  = '0;
    sm_tready = 1'b1;
    exp_valid = 1'b0;
    do_reset();

    // Frame 5,9,3,9,2: tie on 9 keeps the earlier beat.
    vals = '{5, 9, 3, 9, 2};
    for (int i = 0; i < 5; i++) cyc(1'b1, (i == 4), vals[i], 2'd1, 1'b1, a);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, a);

    // Back-to-back single-beat frames.
    cyc(1'b1, 1'b1, 32'd7, 2'd0, 1'b1, a);
    cyc(1'b1, 1'b1, 32'd3, 2'd2, 1'b1, a);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, a);

    // Backpressure: result held while a new beat waits.
    cyc(1'b1, 1'b1, 32'd7, 2'd0, 1'b0, a);
    cyc(1'b1, 1'b0, 32'd4, 2'd0, 1'b0, a);
    cyc(1'b1, 1'b0, 32'd4, 2'd0, 1'b0, a);
    cyc(1'b1, 1'b0, 32'd4, 2'd0, 1'b1, a);
    cyc(1'b1, 1'b1, 32'd1, 2'd0, 1'b1, a);
    cyc(1'b1, 1'b0, 32'd2, 2'd1, 1'b0, a);
    cyc(1'b1, 1'b0, 32'd2, 2'd1, 1'b1, a);
    cyc(1'b1, 1'b1, 32'd8, 2'd1, 1'b1, a);
    // Result taken in the same cycle the next tlast is accepted.
    cyc(1'b1, 1'b1, 32'd5, 2'd3, 1'b1, a);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, a);

    // Length saturation, with and without a mid-frame tid change.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 20; i++)
        cyc(1'b1, (i == 19), (i == 17) ? 32'd1000 : 32'(i + 1),
            (pass == 1 && i == 2) ? 2'd3 : 2'd2, 1'b1, a);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, a);
    end

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd50, 2'd1, 1'b1, a);
    do_reset();
    cyc(1'b1, 1'b0, 32'd6, 2'd2, 1'b1, a);
    cyc(1'b1, 1'b1, 32'd4, 2'd2, 1'b1, a);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, a);

    // Randomized frames with gaps, backpressure, ties and occasional long frames.
    for (int f = 0; f < 60; f++) begin
      int            len;
      logic [TW-1:0] base_tid;
      len = $urandom_range(1, (f % 6 == 0) ? 22 : 6);
      base_tid = TW'($urandom);
      for (int i = 0; i < len; i++) begin
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        d = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 12));
        t = ($urandom_range(0, 9) == 0) ? TW'($urandom) : base_tid;
        send(d, t, (i == len - 1), 70);
      end
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, '0, 1'b1, a);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
